// File: rtl/dm_dmi_responder_if.sv
// DMI request/response and DM CSR register-bus bundle for the core-side DMI responder.
// slave = responder side, master = requester/CSR-file side.
interface dm_dmi_responder_if;
    logic [40:0] dmi_req_i;
    logic        dmi_req_valid_i;
    logic        dmi_req_ready_o;
    logic [33:0] dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i;
    logic        csr_req_o;
    logic        csr_we_o;
    logic [6:0]  csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_gnt_i;
    logic        csr_rvalid_i;
    logic [31:0] csr_rdata_i;
    logic        csr_err_i;

    modport slave (
        input  dmi_req_i, dmi_req_valid_i, dmi_resp_ready_i,
        input  csr_gnt_i, csr_rvalid_i, csr_rdata_i, csr_err_i,
        output dmi_req_ready_o, dmi_resp_o, dmi_resp_valid_o,
        output csr_req_o, csr_we_o, csr_addr_o, csr_wdata_o
    );

    modport master (
        output dmi_req_i, dmi_req_valid_i, dmi_resp_ready_i,
        output csr_gnt_i, csr_rvalid_i, csr_rdata_i, csr_err_i,
        input  dmi_req_ready_o, dmi_resp_o, dmi_resp_valid_o,
        input  csr_req_o, csr_we_o, csr_addr_o, csr_wdata_o
    );
endinterface

// File: rtl/dm_dmi_responder.sv
// DMI request -> single DM CSR access -> response FIFO; read/write response 3 cycles after accept, NOP/illegal 1.
// Backpressure: requests are only taken when idle and a FIFO slot is free, so pushes never stall.
module dm_dmi_responder #(
    parameter int unsigned RespFifoDepth = 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    dm_dmi_responder_if.slave bus
);
    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT
    } state_e;

    localparam logic [1:0] OpNop    = 2'd0;
    localparam logic [1:0] OpRead   = 2'd1;
    localparam logic [1:0] OpWrite  = 2'd2;
    localparam logic [1:0] RespOk   = 2'd0;
    localparam logic [1:0] RespFail = 2'd2;

    localparam int unsigned PtrW = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
    localparam int unsigned CntW = $clog2(RespFifoDepth + 1);
    localparam int unsigned TmoW = 16;

    state_e          state_q;
    logic            csr_req_q;
    logic            csr_we_q;
    logic [6:0]      csr_addr_q;
    logic [31:0]     csr_wdata_q;
    logic [TmoW-1:0] tmo_q;

    dmi_resp_t       mem_q [RespFifoDepth];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] cnt_q;

    dmi_req_t  req;
    dmi_resp_t push_dat;
    logic      push_vld;
    logic      req_rdy;
    logic      accept;
    logic      resp_vld;
    logic      pop;
    logic      tmo_hit;
    logic      is_access;

    assign req       = bus.dmi_req_i;
    assign req_rdy   = (state_q == IDLE) && (cnt_q < CntW'(RespFifoDepth));
    assign accept    = bus.dmi_req_valid_i && req_rdy;
    assign is_access = (req.op == OpRead) || (req.op == OpWrite);
    assign resp_vld  = (cnt_q != '0);
    assign pop       = resp_vld && bus.dmi_resp_ready_i;
    assign tmo_hit   = (tmo_q == TmoW'(TimeoutCycles - 1));

    assign bus.dmi_req_ready_o  = req_rdy;
    assign bus.dmi_resp_valid_o = resp_vld;
    assign bus.dmi_resp_o       = resp_vld ? mem_q[rptr_q] : '0;
    assign bus.csr_req_o        = csr_req_q;
    assign bus.csr_we_o         = csr_we_q;
    assign bus.csr_addr_o       = csr_addr_q;
    assign bus.csr_wdata_o      = csr_wdata_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespFifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // At most one push source per cycle: immediate NOP/illegal-op answers in IDLE, or the CSR completion.
    always_comb begin
        push_vld = 1'b0;
        push_dat = '0;
        unique case (state_q)
            IDLE: begin
                if (accept && !is_access) begin
                    push_vld      = 1'b1;
                    push_dat.resp = (req.op == OpNop) ? RespOk : RespFail;
                end
            end
            WAIT: begin
                if (bus.csr_rvalid_i) begin
                    push_vld      = 1'b1;
                    push_dat.data = csr_we_q ? 32'd0 : bus.csr_rdata_i;
                    push_dat.resp = bus.csr_err_i ? RespFail : RespOk;
                end else if (tmo_hit) begin
                    push_vld      = 1'b1;
                    push_dat.resp = RespFail;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= IDLE;
            csr_req_q   <= 1'b0;
            csr_we_q    <= 1'b0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
            tmo_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (accept && is_access) begin
                        state_q     <= ACCESS;
                        csr_req_q   <= 1'b1;
                        csr_we_q    <= (req.op == OpWrite);
                        csr_addr_q  <= req.addr;
                        csr_wdata_q <= req.data;
                    end
                end
                ACCESS: begin
                    if (bus.csr_gnt_i) begin
                        state_q   <= WAIT;
                        csr_req_q <= 1'b0;
                        tmo_q     <= '0;
                    end
                end
                WAIT: begin
                    if (bus.csr_rvalid_i || tmo_hit) begin
                        state_q <= IDLE;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    csr_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_vld) begin
                mem_q[wptr_q] <= push_dat;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            unique case ({push_vld, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_dmi_responder.sv
// Directed bench: stimulus pushes expected responses/CSR accesses into queues; monitors pop and compare.
module tb_dm_dmi_responder;
    logic clk_i = 1'b0;
    logic rst_i;
    logic clear_i;
    always #5 clk_i = ~clk_i;

    dm_dmi_responder_if bus ();

    dm_dmi_responder #(
        .RespFifoDepth(2),
        .TimeoutCycles(4)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(clear_i),
        .bus    (bus)
    );

    typedef struct {
        logic [33:0] resp;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } csr_exp_t;

    exp_t     exp_q[$];
    csr_exp_t csr_q[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;

    logic        csr_hang = 1'b0;
    logic [31:0] csr_rdata_v = '0;
    logic        csr_err_v = 1'b0;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (bus.dmi_resp_valid_o === 1'b1 && bus.dmi_resp_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got %h, required no response", bus.dmi_resp_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp", 64'(bus.dmi_resp_o), 64'(e.resp));
                    if (e.cyc >= 0) chk("resp_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // CSR file model: grants in the request cycle, completes one cycle later unless hung
    initial begin
        csr_exp_t c;
        bus.csr_gnt_i    = 1'b0;
        bus.csr_rvalid_i = 1'b0;
        bus.csr_rdata_i  = '0;
        bus.csr_err_i    = 1'b0;
        forever begin
            @(negedge clk_i);
            if (bus.csr_req_o === 1'b1) begin
                if (csr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_csr_req: got addr %h, required no access", bus.csr_addr_o);
                end else begin
                    c = csr_q.pop_front();
                    chk("csr_we", 64'(bus.csr_we_o), 64'(c.we));
                    chk("csr_addr", 64'(bus.csr_addr_o), 64'(c.addr));
                    if (c.we) chk("csr_wdata", 64'(bus.csr_wdata_o), 64'(c.wdata));
                end
                bus.csr_gnt_i = 1'b1;
                @(posedge clk_i);
                #1;
                bus.csr_gnt_i = 1'b0;
                if (csr_hang) repeat (5) begin
                    @(posedge clk_i);
                    #1;
                end
                bus.csr_rvalid_i = 1'b1;
                bus.csr_rdata_i  = csr_hang ? 32'hBAD0BAD0 : csr_rdata_v;
                bus.csr_err_i    = csr_err_v;
                @(posedge clk_i);
                #1;
                bus.csr_rvalid_i = 1'b0;
                bus.csr_rdata_i  = '0;
                bus.csr_err_i    = 1'b0;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                        input bit push_exp, input logic [33:0] exp_resp, input int lat);
        int       n = 0;
        exp_t     e;
        csr_exp_t c;
        bus.dmi_req_i       = {a, op, d};
        bus.dmi_req_valid_i = 1'b1;
        @(negedge clk_i);
        while (bus.dmi_req_ready_o !== 1'b1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready_o stayed %b, required 1", bus.dmi_req_ready_o);
        end else begin
            if (op == 2'd1 || op == 2'd2) begin
                c.we    = (op == 2'd2);
                c.addr  = a;
                c.wdata = d;
                csr_q.push_back(c);
            end
            if (push_exp) begin
                e.resp = exp_resp;
                e.cyc  = (lat < 0) ? -1 : cyc + lat;
                exp_q.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
        bus.dmi_req_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        rst_i                = 1'b1;
        clear_i              = 1'b0;
        bus.dmi_req_i        = '0;
        bus.dmi_req_valid_i  = 1'b0;
        bus.dmi_resp_ready_i = 1'b1;
        idle(3);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_resp_valid", 64'(bus.dmi_resp_valid_o), 64'(1'b0));
        chk("rst_resp", 64'(bus.dmi_resp_o), 64'(1'b0));
        chk("rst_csr_req", 64'(bus.csr_req_o), 64'(1'b0));
        chk("rst_csr_we", 64'(bus.csr_we_o), 64'(1'b0));
        chk("rst_csr_addr", 64'(bus.csr_addr_o), 64'(1'b0));
        chk("rst_csr_wdata", 64'(bus.csr_wdata_o), 64'(1'b0));
        chk("rst_req_ready", 64'(bus.dmi_req_ready_o), 64'(1'b1));
        idle(1);

        // Read and write round trips
        csr_rdata_v = 32'hDEADBEEF;
        send(2'd1, 7'h11, 32'h0, 1'b1, {32'hDEADBEEF, 2'd0}, 3);
        idle(5);
        send(2'd2, 7'h04, 32'h12345678, 1'b1, {32'h0, 2'd0}, 3);
        idle(5);

        // NOP and illegal op answer next cycle without a CSR access
        send(2'd0, 7'h01, 32'hFFFFFFFF, 1'b1, {32'h0, 2'd0}, 1);
        send(2'd3, 7'h02, 32'hFFFFFFFF, 1'b1, {32'h0, 2'd2}, 1);
        idle(3);

        // FIFO full backpressure, order preserved
        bus.dmi_resp_ready_i = 1'b0;
        send(2'd0, 7'h03, 32'h0, 1'b1, {32'h0, 2'd0}, -1);
        send(2'd3, 7'h05, 32'h0, 1'b1, {32'h0, 2'd2}, -1);
        bus.dmi_req_i       = {7'h06, 2'd0, 32'h0};
        bus.dmi_req_valid_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("full_req_ready", 64'(bus.dmi_req_ready_o), 64'(1'b0));
        chk("full_resp_valid", 64'(bus.dmi_resp_valid_o), 64'(1'b1));
        chk("full_head", 64'(bus.dmi_resp_o), 64'({32'h0, 2'd0}));
        idle(1);
        bus.dmi_resp_ready_i = 1'b1;
        send(2'd0, 7'h06, 32'h0, 1'b1, {32'h0, 2'd0}, -1);
        idle(5);

        // Timeout, stale rvalid ignored, then a normal read
        csr_hang = 1'b1;
        send(2'd1, 7'h20, 32'h0, 1'b1, {32'h0, 2'd2}, 6);
        idle(14);
        csr_hang    = 1'b0;
        csr_rdata_v = 32'hCAFEF00D;
        send(2'd1, 7'h21, 32'h0, 1'b1, {32'hCAFEF00D, 2'd0}, 3);
        idle(5);

        // CSR error on completion
        csr_err_v = 1'b1;
        send(2'd2, 7'h10, 32'hA5A5A5A5, 1'b1, {32'h0, 2'd2}, 3);
        idle(5);
        csr_err_v = 1'b0;

        // Clear with a full FIFO
        bus.dmi_resp_ready_i = 1'b0;
        send(2'd0, 7'h07, 32'h0, 1'b0, '0, -1);
        send(2'd3, 7'h08, 32'h0, 1'b0, '0, -1);
        clear_i = 1'b1;
        idle(1);
        clear_i = 1'b0;
        @(negedge clk_i);
        chk("clr_full_resp_valid", 64'(bus.dmi_resp_valid_o), 64'(1'b0));
        chk("clr_full_req_ready", 64'(bus.dmi_req_ready_o), 64'(1'b1));
        idle(1);

        // Clear while waiting on the CSR with a queued response
        send(2'd0, 7'h09, 32'h0, 1'b0, '0, -1);
        csr_hang = 1'b1;
        send(2'd1, 7'h30, 32'h0, 1'b0, '0, -1);
        idle(2);
        clear_i = 1'b1;
        idle(1);
        clear_i = 1'b0;
        @(negedge clk_i);
        chk("clr_wait_resp_valid", 64'(bus.dmi_resp_valid_o), 64'(1'b0));
        chk("clr_wait_resp", 64'(bus.dmi_resp_o), 64'(1'b0));
        chk("clr_wait_csr_req", 64'(bus.csr_req_o), 64'(1'b0));
        chk("clr_wait_req_ready", 64'(bus.dmi_req_ready_o), 64'(1'b1));
        bus.dmi_resp_ready_i = 1'b1;
        idle(12);
        csr_hang = 1'b0;

        send(2'd3, 7'h0A, 32'h0, 1'b1, {32'h0, 2'd2}, 1);
        idle(5);
        chk("exp_queue_drained", 64'(exp_q.size()), 64'(0));
        chk("csr_queue_drained", 64'(csr_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
